// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I MEM stage: load/store unit with req/ack data bus and MEM/WB register
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        crt_wb_in,
    input  logic [2:0]        crt_mem_in,
    input  logic [2:0]        funct3_in,
    input  logic [31:0]       pc_in,
    input  logic              zero_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       dato_b_in,
    input  logic [4:0]        rd_in,
    output logic              stall_out,
    output logic              pc_src_out,
    output logic [31:0]       pc_target_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_alu_result,
    output logic [31:0]       wb_load_data,
    output logic              misalign_err,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

    state_t state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              wbv_q, wbv_d, wbrw_q, wbrw_d, wbm2r_q, wbm2r_d;
    logic [4:0]        wbrd_q, wbrd_d;
    logic [31:0]       wbalu_q, wbalu_d, wbld_q, wbld_d;
    logic              mis_q, mis_d, berr_q, berr_d;
    logic [2:0]        p_f3_q, p_f3_d;
    logic [1:0]        p_off_q, p_off_d, p_wb_q, p_wb_d;
    logic [4:0]        p_rd_q, p_rd_d;
    logic [31:0]       p_alu_q, p_alu_d;

    logic        is_store, mem_op, aligned;
    logic [1:0]  off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, rd_shift, load_ext;

    assign pc_src_out    = in_valid & crt_mem_in[0] & zero_in;
    assign pc_target_out = pc_in;
    assign is_store      = crt_mem_in[1];
    assign mem_op        = in_valid & (crt_mem_in[2] | crt_mem_in[1]);
    assign off           = alu_result_in[1:0];

    // Unsigned load encodings have no store counterpart, so they count as misaligned for stores.
    always_comb begin
        aligned = 1'b0;
        case (funct3_in)
            3'b000:  aligned = 1'b1;
            3'b001:  aligned = ~off[0];
            3'b010:  aligned = (off == 2'b00);
            3'b100:  aligned = ~is_store;
            3'b101:  aligned = ~is_store & ~off[0];
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = dato_b_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{dato_b_in[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << off;
                wdata_c = {2{dato_b_in[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_shift = dmem_rdata >> {p_off_q, 3'b000};
    always_comb begin
        load_ext = dmem_rdata;
        case (p_f3_q)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'd0, rd_shift[7:0]};
            3'b101:  load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        wbv_d   = wbv_q;
        wbrw_d  = wbrw_q;
        wbm2r_d = wbm2r_q;
        wbrd_d  = wbrd_q;
        wbalu_d = wbalu_q;
        wbld_d  = wbld_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        p_f3_d  = p_f3_q;
        p_off_d = p_off_q;
        p_wb_d  = p_wb_q;
        p_rd_d  = p_rd_q;
        p_alu_d = p_alu_q;
        stall_out = 1'b0;
        case (state_q)
            // ERR only marks the recovery cycle; upstream is already released, so it accepts like IDLE.
            IDLE, ERR: begin
                state_d = IDLE;
                if (mem_op && aligned) begin
                    stall_out = 1'b1;
                    state_d   = ACCESS;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {alu_result_in[ADDR_W-1:2], 2'b00};
                    be_d      = be_c;
                    wdata_d   = wdata_c;
                    cnt_d     = 8'd0;
                    wbv_d     = 1'b0;
                    wbrw_d    = 1'b0;
                    p_f3_d    = funct3_in;
                    p_off_d   = off;
                    p_wb_d    = crt_wb_in;
                    p_rd_d    = rd_in;
                    p_alu_d   = alu_result_in;
                end else if (in_valid) begin
                    mis_d   = mem_op;
                    wbv_d   = 1'b1;
                    wbrw_d  = crt_wb_in[1] & ~mem_op;
                    wbm2r_d = crt_wb_in[0];
                    wbrd_d  = rd_in;
                    wbalu_d = alu_result_in;
                    wbld_d  = 32'd0;
                end else begin
                    wbv_d  = 1'b0;
                    wbrw_d = 1'b0;
                end
            end
            ACCESS: begin
                stall_out = 1'b1;
                if (dmem_ack || cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    req_d   = 1'b0;
                    wbv_d   = 1'b1;
                    wbm2r_d = p_wb_q[0];
                    wbrd_d  = p_rd_q;
                    wbalu_d = p_alu_q;
                    if (dmem_ack) begin
                        state_d = IDLE;
                        wbrw_d  = p_wb_q[1];
                        wbld_d  = we_q ? 32'd0 : load_ext;
                    end else begin
                        state_d = ERR;
                        berr_d  = 1'b1;
                        wbrw_d  = 1'b0;
                        wbld_d  = 32'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            wbv_q   <= 1'b0;
            wbrw_q  <= 1'b0;
            wbm2r_q <= 1'b0;
            wbrd_q  <= 5'd0;
            wbalu_q <= 32'd0;
            wbld_q  <= 32'd0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            p_f3_q  <= 3'd0;
            p_off_q <= 2'd0;
            p_wb_q  <= 2'd0;
            p_rd_q  <= 5'd0;
            p_alu_q <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            wbv_q   <= wbv_d;
            wbrw_q  <= wbrw_d;
            wbm2r_q <= wbm2r_d;
            wbrd_q  <= wbrd_d;
            wbalu_q <= wbalu_d;
            wbld_q  <= wbld_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            p_f3_q  <= p_f3_d;
            p_off_q <= p_off_d;
            p_wb_q  <= p_wb_d;
            p_rd_q  <= p_rd_d;
            p_alu_q <= p_alu_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wbv_q;
    assign wb_reg_write  = wbrw_q;
    assign wb_mem_to_reg = wbm2r_q;
    assign wb_rd         = wbrd_q;
    assign wb_alu_result = wbalu_q;
    assign wb_load_data  = wbld_q;
    assign misalign_err  = mis_q;
    assign bus_err       = berr_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu against a transaction-level model
module tb_mem_stage_lsu;
    localparam int T = 4;

    logic        clk, rst, in_valid, zero_in, dmem_ack;
    logic [1:0]  crt_wb_in;
    logic [2:0]  crt_mem_in, funct3_in;
    logic [31:0] pc_in, alu_result_in, dato_b_in, dmem_rdata;
    logic [4:0]  rd_in;
    logic        stall_out, pc_src_out, dmem_req, dmem_we;
    logic [31:0] pc_target_out, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, misalign_err, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result, wb_load_data;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .crt_wb_in(crt_wb_in),
        .crt_mem_in(crt_mem_in), .funct3_in(funct3_in), .pc_in(pc_in),
        .zero_in(zero_in), .alu_result_in(alu_result_in), .dato_b_in(dato_b_in),
        .rd_in(rd_in), .stall_out(stall_out), .pc_src_out(pc_src_out),
        .pc_target_out(pc_target_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One instruction from presentation until retirement; lat = ACCESS cycles without ack before
    // the ack cycle (negative or >= T means the memory never answers).
    task automatic run_op(input logic v, input logic [1:0] wb, input logic [2:0] mem,
                          input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input logic [31:0] rdat,
                          input logic z, input logic [31:0] pc);
        int sz, stalls, exp_stalls;
        logic mop, st, al;
        logic [1:0] off;
        logic [3:0] be;
        logic [31:0] wd, ld, sh;
        @(negedge clk);
        in_valid = v; crt_wb_in = wb; crt_mem_in = mem; funct3_in = f3;
        alu_result_in = alu; dato_b_in = b; rd_in = rd; zero_in = z; pc_in = pc;
        dmem_ack = 1'b0; dmem_rdata = rdat;

        mop = v && (mem[2] || mem[1]);
        st  = mem[1];
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        if (st && f3[2]) sz = 0;
        off = alu[1:0];
        al  = (sz != 0) && ((int'(off) % sz) == 0);
        be  = 4'(((1 << sz) - 1) << off);
        wd  = (sz == 1) ? {4{b[7:0]}} : (sz == 2) ? {2{b[15:0]}} : b;
        sh  = rdat >> (8 * int'(off));
        if (sz == 1)      ld = f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
        else if (sz == 2) ld = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        else              ld = rdat;

        #1;
        check("pc_src", pc_src_out, v & mem[0] & z);
        check("pc_target", pc_target_out, pc);
        check("stall_accept", stall_out, mop & al);
        stalls = (mop && al) ? 1 : 0;
        @(posedge clk); #1;
        if (!mop) begin
            check("wb_valid", wb_valid, v);
            check("wb_reg_write", wb_reg_write, v & wb[1]);
            check("misalign_idle", misalign_err, 1'b0);
            check("req_idle", dmem_req, 1'b0);
            if (v) begin
                check("wb_rd", wb_rd, rd);
                check("wb_alu", wb_alu_result, alu);
                check("wb_m2r", wb_mem_to_reg, wb[0]);
                check("wb_load_zero", wb_load_data, 32'd0);
            end
            return;
        end
        if (!al) begin
            check("mis_req", dmem_req, 1'b0);
            check("mis_err", misalign_err, 1'b1);
            check("mis_wb_valid", wb_valid, 1'b1);
            check("mis_reg_write", wb_reg_write, 1'b0);
            return;
        end
        check("req", dmem_req, 1'b1);
        check("we", dmem_we, st);
        check("addr", dmem_addr, {alu[31:2], 2'b00});
        check("be", dmem_be, be);
        check("wdata", dmem_wdata, wd);
        check("issue_wb_valid", wb_valid, 1'b0);
        for (int i = 0; i < T; i++) begin
            @(negedge clk);
            dmem_ack = (i == lat);
            #1;
            check("stall_access", stall_out, 1'b1);
            stalls++;
            @(posedge clk); #1;
            if (i == lat) begin
                check("done_req", dmem_req, 1'b0);
                check("done_wb_valid", wb_valid, 1'b1);
                check("done_reg_write", wb_reg_write, wb[1]);
                check("done_rd", wb_rd, rd);
                check("done_load", wb_load_data, st ? 32'd0 : ld);
                check("done_bus_err", bus_err, 1'b0);
                break;
            end else if (i == T - 1) begin
                check("to_bus_err", bus_err, 1'b1);
                check("to_req", dmem_req, 1'b0);
                check("to_wb_valid", wb_valid, 1'b1);
                check("to_reg_write", wb_reg_write, 1'b0);
            end else begin
                check("hold_req", dmem_req, 1'b1);
                check("hold_addr", dmem_addr, {alu[31:2], 2'b00});
                check("hold_wb_valid", wb_valid, 1'b0);
            end
        end
        exp_stalls = (lat >= 0 && lat < T) ? lat + 2 : T + 1;
        check("stall_count", stalls, exp_stalls);
    endtask

    initial begin
        logic [2:0] f3s [5];
        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4; f3s[4] = 3'd5;
        rst = 1'b1; in_valid = 1'b0; crt_wb_in = 2'd0; crt_mem_in = 3'd0; funct3_in = 3'd0;
        pc_in = 32'd0; zero_in = 1'b0; alu_result_in = 32'd0; dato_b_in = 32'd0; rd_in = 5'd0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        @(negedge clk); rst = 1'b0;

        // reset while an access is outstanding
        @(negedge clk);
        in_valid = 1'b1; crt_wb_in = 2'b11; crt_mem_in = 3'b100; funct3_in = 3'd2;
        alu_result_in = 32'h0000_0200; rd_in = 5'd3;
        @(posedge clk); #1;
        check("r1_req", dmem_req, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; crt_mem_in = 3'd0; rst = 1'b1;
        #1;
        check("r1_req_async", dmem_req, 1'b0);
        check("r1_addr", dmem_addr, 32'd0);
        check("r1_be", dmem_be, 4'd0);
        check("r1_wdata", dmem_wdata, 32'd0);
        check("r1_stall", stall_out, 1'b0);
        check("r1_wb_valid", wb_valid, 1'b0);
        @(negedge clk); rst = 1'b0; dmem_ack = 1'b1;
        @(posedge clk); #1;
        check("r1_late_ack", wb_valid, 1'b0);
        @(negedge clk); dmem_ack = 1'b0;

        run_op(1, 2'b10, 3'b000, 3'd0, 32'h0000_1234, 32'd0, 5'd5, 0, 32'd0, 0, 32'h40);
        run_op(1, 2'b00, 3'b010, 3'd0, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 3, 32'd0, 1, 32'h80);
        run_op(1, 2'b11, 3'b100, 3'd0, 32'h0000_0102, 32'd0, 5'd7, 0, 32'h0080_0000, 0, 32'd0);
        run_op(1, 2'b11, 3'b100, 3'd4, 32'h0000_0102, 32'd0, 5'd7, 1, 32'h0080_0000, 0, 32'd0);
        run_op(1, 2'b11, 3'b100, 3'd1, 32'h0000_0102, 32'd0, 5'd8, 2, 32'h8001_0000, 0, 32'd0);
        run_op(1, 2'b11, 3'b100, 3'd2, 32'h0000_0101, 32'd0, 5'd9, 0, 32'd0, 0, 32'd0);
        run_op(1, 2'b00, 3'b010, 3'd1, 32'h0000_0103, 32'h1234_5678, 5'd0, 0, 32'd0, 0, 32'd0);
        run_op(1, 2'b11, 3'b100, 3'd2, 32'h0000_0200, 32'd0, 5'd10, -1, 32'd0, 0, 32'd0);
        run_op(1, 2'b11, 3'b100, 3'd2, 32'h0000_0204, 32'd0, 5'd11, T - 1, 32'hCAFE_F00D, 0, 32'd0);
        run_op(0, 2'b11, 3'b000, 3'd0, 32'h0000_0055, 32'd0, 5'd12, 0, 32'd0, 1, 32'd0);

        for (int n = 0; n < 200; n++) begin
            int kind;
            logic [2:0] mem, f3;
            logic [31:0] alu;
            kind = int'($urandom_range(0, 4));
            f3   = f3s[$urandom_range(0, 4)];
            alu  = $urandom;
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            case (kind)
                0: mem = 3'b000;
                1: mem = 3'b100;
                2: begin mem = 3'b010; f3 = f3s[$urandom_range(0, 2)]; end
                3: mem = 3'b110;
                default: mem = 3'b001;
            endcase
            if (kind == 4 && $urandom_range(0, 7) == 0) f3 = 3'($urandom);
            run_op($urandom_range(0, 7) != 0, 2'($urandom), mem, f3, alu, $urandom,
                   5'($urandom), int'($urandom_range(0, 5)), $urandom, 1'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
